// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_fifo_if : byte-ingress and FWFT-egress bundle of the UART RX buffer
// Rev 1.0
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_perr;
  logic [7:0] dout;
  logic       dout_perr;
  logic       dout_valid;
  logic       dout_ready;

  modport master (
    output din, din_valid, din_perr, dout_ready,
    input  dout, dout_perr, dout_valid
  );

  modport slave (
    input  din, din_valid, din_perr, dout_ready,
    output dout, dout_perr, dout_valid
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_fifo : first-word-fall-through byte buffer behind a UART receiver,
//                with parity tag, sticky overrun and RTS flow control
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AF_LEVEL  = 12,
  parameter int DROP_PERR = 0
) (
  input  wire logic                       clk_i,
  input  wire logic                       rst_ni,
  uart_rx_fifo_if.slave                   bus,
  input  wire logic                       clr_overrun_i,
  output logic [$clog2(DEPTH+1)-1:0]      count_o,
  output logic                            full_o,
  output logic                            overrun_o,
  output logic                            rts_n_o
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_AF    = c_CW'(AF_LEVEL);

  logic [8:0]      mem_q [DEPTH];
  logic [c_AW-1:0] wptr_q, rptr_q;
  logic [c_CW-1:0] count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            rts_n_q;
  logic            w_push, w_pop, w_drop, w_lost, w_full, w_valid;
  logic [8:0]      w_head;

  assign w_full  = (count_q == c_DEPTH);
  assign w_valid = (count_q != '0);
  assign w_drop  = (DROP_PERR != 0) && bus.din_perr;
  assign w_pop   = w_valid && bus.dout_ready;
  assign w_push  = bus.din_valid && (!w_full || w_pop) && !w_drop;
  // A full queue accepts a byte only when the head leaves in the same cycle
  assign w_lost  = bus.din_valid && w_full && !w_pop && !w_drop;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CW'(1);
      2'b01:   count_d = count_q - c_CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (clr_overrun_i) overrun_d = 1'b0;
    if (w_lost)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      rts_n_q   <= 1'b0;
    end else begin
      if (w_push) wptr_q <= wptr_q + c_AW'(1);
      if (w_pop)  rptr_q <= rptr_q + c_AW'(1);
      count_q   <= count_d;
      overrun_q <= overrun_d;
      rts_n_q   <= (count_d >= c_AF);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wptr_q] <= {bus.din_perr, bus.din};
  end

  assign w_head         = mem_q[rptr_q];
  assign bus.dout       = w_valid ? w_head[7:0] : 8'h00;
  assign bus.dout_perr  = w_valid ? w_head[8]   : 1'b0;
  assign bus.dout_valid = w_valid;
  assign count_o        = count_q;
  assign full_o         = w_full;
  assign overrun_o      = overrun_q;
  assign rts_n_o        = rts_n_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo : randomized self-checking bench against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr0 = 1'b0, clr1 = 1'b0;
  logic [4:0] cnt0, cnt1;
  logic full0, full1, ovr0, ovr1, rts0, rts1;
  int errors = 0;
  int checks = 0;

  logic [8:0] mq[$];
  logic       m_ovr;

  uart_rx_fifo_if b0 ();
  uart_rx_fifo_if b1 ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF), .DROP_PERR(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b0.slave), .clr_overrun_i(clr0),
    .count_o(cnt0), .full_o(full0), .overrun_o(ovr0), .rts_n_o(rts0));

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF), .DROP_PERR(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b1.slave), .clr_overrun_i(clr1),
    .count_o(cnt1), .full_o(full1), .overrun_o(ovr1), .rts_n_o(rts1));

  always #5 clk = ~clk;

  // One clock on dut0 with the model advanced from the pre-edge state
  task automatic step(input logic [7:0] d, input logic v, input logic p,
                      input logic r, input logic c);
    logic pop;
    b0.din = d; b0.din_valid = v; b0.din_perr = p; b0.dout_ready = r; clr0 = c;
    @(posedge clk);
    pop = (mq.size() != 0) && r;
    if (c) m_ovr = 1'b0;
    if (v && !pop && mq.size() == DEPTH) m_ovr = 1'b1;
    if (pop) void'(mq.pop_front());
    if (v && mq.size() < DEPTH) mq.push_back({p, d});
    @(negedge clk);
    b0.din_valid = 1'b0; b0.dout_ready = 1'b0; clr0 = 1'b0; b0.din_perr = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (cnt0 !== 5'd0 || b0.dout_valid !== 1'b0 || b0.dout !== 8'h00 || full0 !== 1'b0
        || ovr0 !== 1'b0 || rts0 !== 1'b0) begin
      errors++;
      $display("FAIL reset: cnt=%0d vld=%b dout=%h full=%b ovr=%b rts=%b, want all 0",
               cnt0, b0.dout_valid, b0.dout, full0, ovr0, rts0);
    end
  endtask

  task automatic test_basic;
    step(8'h41, 1, 0, 0, 0);
    step(8'h42, 1, 0, 0, 0);
    step(8'h43, 1, 0, 0, 0);
    checks++;
    if (cnt0 !== 5'd3 || b0.dout !== 8'h41 || b0.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_fill: cnt=%0d dout=%h vld=%b, want 3 41 1", cnt0, b0.dout, b0.dout_valid);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] exp;
      step(8'h00, 0, 0, 1, 0);
      exp = (i == 0) ? 8'h42 : (i == 1) ? 8'h43 : 8'h00;
      checks++;
      if (b0.dout !== exp || b0.dout_valid !== (i < 2) || cnt0 !== 5'(2 - i)) begin
        errors++;
        $display("FAIL basic_drain[%0d]: dout=%h vld=%b cnt=%0d, want %h %b %0d",
                 i, b0.dout, b0.dout_valid, cnt0, exp, (i < 2), 2 - i);
      end
    end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 16; i++) step(8'(i), 1, 0, 0, 0);
    checks++;
    if (full0 !== 1'b1 || cnt0 !== 5'd16) begin
      errors++;
      $display("FAIL full: full=%b cnt=%0d, want 1 16", full0, cnt0);
    end
    step(8'hAA, 1, 0, 0, 0);
    checks++;
    if (ovr0 !== 1'b1 || b0.dout !== 8'h00 || cnt0 !== 5'd16) begin
      errors++;
      $display("FAIL overrun_set: ovr=%b dout=%h cnt=%0d, want 1 00 16", ovr0, b0.dout, cnt0);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (b0.dout !== 8'(i) || b0.dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL overrun_drain[%0d]: dout=%h vld=%b, want %h 1", i, b0.dout, b0.dout_valid, 8'(i));
      end
      step(8'h00, 0, 0, 1, 0);
    end
    checks++;
    if (b0.dout_valid !== 1'b0 || ovr0 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: vld=%b ovr=%b, want 0 1", b0.dout_valid, ovr0);
    end
    step(8'h00, 0, 0, 0, 1);
    checks++;
    if (ovr0 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clr: ovr=%b, want 0", ovr0);
    end
  endtask

  task automatic test_full_pop_push;
    for (int i = 0; i < 16; i++) step(8'($urandom_range(0, 255)), 1, 0, 0, 0);
    step(8'h55, 1, 0, 1, 0);
    checks++;
    if (cnt0 !== 5'd16 || ovr0 !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_push: cnt=%0d ovr=%b, want 16 0", cnt0, ovr0);
    end
    while (mq.size() > 0) begin
      checks++;
      if (b0.dout !== mq[0][7:0] || b0.dout_perr !== mq[0][8]) begin
        errors++;
        $display("FAIL full_pop_push_drain: dout=%h perr=%b, want %h %b",
                 b0.dout, b0.dout_perr, mq[0][7:0], mq[0][8]);
      end
      if (mq.size() == 1) begin
        checks++;
        if (b0.dout !== 8'h55) begin
          errors++;
          $display("FAIL full_pop_push_last: dout=%h, want 55", b0.dout);
        end
      end
      step(8'h00, 0, 0, 1, 0);
    end
  endtask

  task automatic test_parity;
    step(8'h12, 1, 1, 0, 0);
    checks++;
    if (b0.dout !== 8'h12 || b0.dout_perr !== 1'b1 || cnt0 !== 5'd1) begin
      errors++;
      $display("FAIL perr_keep: dout=%h perr=%b cnt=%0d, want 12 1 1", b0.dout, b0.dout_perr, cnt0);
    end
    step(8'h00, 0, 0, 1, 0);
    b1.din = 8'h12; b1.din_perr = 1'b1; b1.din_valid = 1'b1; b1.dout_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b1.din_valid = 1'b0; b1.din_perr = 1'b0;
    checks++;
    if (cnt1 !== 5'd0 || b1.dout_valid !== 1'b0 || ovr1 !== 1'b0 || b1.dout !== 8'h00) begin
      errors++;
      $display("FAIL perr_drop: cnt=%0d vld=%b ovr=%b dout=%h, want 0 0 0 00",
               cnt1, b1.dout_valid, ovr1, b1.dout);
    end
    b1.din = 8'h34; b1.din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.din_valid = 1'b0;
    checks++;
    if (cnt1 !== 5'd1 || b1.dout !== 8'h34 || b1.dout_perr !== 1'b0) begin
      errors++;
      $display("FAIL perr_drop_clean: cnt=%0d dout=%h perr=%b, want 1 34 0", cnt1, b1.dout, b1.dout_perr);
    end
  endtask

  task automatic test_rts;
    for (int i = 0; i < 11; i++) step(8'($urandom_range(0, 255)), 1, 0, 0, 0);
    checks++;
    if (rts0 !== 1'b0 || cnt0 !== 5'd11) begin
      errors++;
      $display("FAIL rts_below: rts=%b cnt=%0d, want 0 11", rts0, cnt0);
    end
    step(8'hC3, 1, 0, 0, 0);
    checks++;
    if (rts0 !== 1'b1) begin
      errors++;
      $display("FAIL rts_at: rts=%b, want 1", rts0);
    end
    step(8'h00, 0, 0, 1, 0);
    checks++;
    if (rts0 !== 1'b0) begin
      errors++;
      $display("FAIL rts_pop: rts=%b, want 0", rts0);
    end
    while (mq.size() > 0) step(8'h00, 0, 0, 1, 0);
  endtask

  task automatic test_random_stream;
    int sent = 0;
    int cyc = 0;
    while ((sent < 40 || mq.size() > 0) && cyc < 2000) begin
      logic v, r, p;
      v = (sent < 40) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      p = ($urandom_range(0, 7) == 0);
      if (v) sent++;
      step(8'($urandom_range(0, 255)), v, p, r, 0);
      cyc++;
      checks++;
      if (b0.dout_valid !== (mq.size() != 0) || cnt0 !== 5'(mq.size())
          || b0.dout !== (mq.size() != 0 ? mq[0][7:0] : 8'h00)
          || b0.dout_perr !== (mq.size() != 0 ? mq[0][8] : 1'b0)
          || full0 !== (mq.size() == DEPTH) || ovr0 !== m_ovr || rts0 !== (mq.size() >= AF)) begin
        errors++;
        $display("FAIL random[%0d]: vld=%b cnt=%0d dout=%h perr=%b ovr=%b rts=%b, want cnt=%0d ovr=%b",
                 cyc, b0.dout_valid, cnt0, b0.dout, b0.dout_perr, ovr0, rts0, mq.size(), m_ovr);
      end
    end
    checks++;
    if (cyc >= 2000) begin
      errors++;
      $display("FAIL random_timeout: cycles=%0d, want < 2000", cyc);
    end
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 17; i++) step(8'(i + 8'h80), 1, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(8'h00, 0, 0, 1, 0);
    checks++;
    if (cnt0 !== 5'd5 || ovr0 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: cnt=%0d ovr=%b, want 5 1", cnt0, ovr0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cnt0 !== 5'd0 || b0.dout_valid !== 1'b0 || ovr0 !== 1'b0 || rts0 !== 1'b0
        || b0.dout !== 8'h00 || full0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d vld=%b ovr=%b rts=%b dout=%h, want 0 0 0 0 00",
               cnt0, b0.dout_valid, ovr0, rts0, b0.dout);
    end
    mq.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_ovr = 1'b0;
    b0.din = 8'h00; b0.din_valid = 1'b0; b0.din_perr = 1'b0; b0.dout_ready = 1'b0;
    b1.din = 8'h00; b1.din_valid = 1'b0; b1.din_perr = 1'b0; b1.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_basic;
    test_overrun;
    test_full_pop_push;
    test_parity;
    test_rts;
    test_random_stream;
    test_reset_midstream;
    test_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART receiver.
- Captures each completed byte together with its parity-error tag when the receiver pulses its data-ready strobe.
- Presents the buffered bytes to the consumer through a first-word-fall-through valid/ready interface.
- Tracks overrun and drives an RTS-style flow-control output so the far end can be throttled before bytes are lost.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- AF_LEVEL, 12, occupancy at or above which rts_n deasserts (1); range 1..DEPTH.
- DROP_PERR, 0, when 1, bytes arriving with din_perr=1 are discarded and never stored.

Ports:
- clk  in  1  block clock, shared with the UART receiver.
- rst  in  1  reset, asynchronous, active-low.
- din  in  8  received byte (receiver data output).
- din_valid  in  1  one-cycle strobe: din/din_perr valid this cycle.
- din_perr  in  1  parity-error tag for din.
- dout  out  8  byte at head of queue; 0 when empty.
- dout_perr  out  1  parity tag of head entry; 0 when empty.
- dout_valid  out  1  queue not empty.
- dout_ready  in  1  consumer accepts head entry this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.
- overrun  out  1  sticky: a byte was lost because the queue was full.
- clr_overrun  in  1  synchronous clear of overrun.
- rts_n  out  1  0 = peer may send; 1 = stop (count >= AF_LEVEL).

Behaviour:
- Reset: asynchronous, active-low, applied immediately, including mid-transfer.
  - Clears: write pointer, read pointer, count, overrun; sets rts_n=0.
  - Outputs while in reset: dout=0, dout_perr=0, dout_valid=0, full=0.
  - Storage array is not reset; its contents are don't-care after reset.
- Storage: DEPTH x 9 bits (byte plus perr tag).
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy is held in a separate counter.
- Push:
  - push = din_valid & (!full | pop) & !(DROP_PERR & din_perr).
  - On push, {din_perr, din} is written at the write pointer and the write pointer increments.
- Pop:
  - pop = dout_valid & dout_ready; read pointer increments on pop.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- First-word fall-through:
  - dout/dout_perr are read combinationally from storage at the read pointer, gated to 0 when empty.
  - A byte pushed at edge N is on dout with dout_valid=1 from just after edge N. Latency is 1 clock from the din_valid cycle.
- Empty with din_valid and dout_ready in the same cycle: no bypass. The byte is stored; pop is 0 because dout_valid=0.
- Full with din_valid and pop in the same cycle: the push is accepted, count stays DEPTH, and overrun is not set.
- Full with din_valid and no pop:
  - The byte is discarded; storage and pointers are unchanged.
  - overrun is set to 1 at that edge.
- Discard under DROP_PERR=1 when din_perr=1: no push, no overrun, no count change, regardless of full.
- overrun:
  - Stays 1 until a clock edge with clr_overrun=1.
  - If clr_overrun and a new overrun event occur in the same cycle, the set wins (overrun=1).
- full and dout_valid are combinational from count (full = count==DEPTH, dout_valid = count!=0).
- rts_n:
  - Registered from the next-count value: rts_n <= (count_next >= AF_LEVEL).
  - Changes on the same edge that count crosses the threshold.
- dout_ready while empty: ignored.
- din_valid is treated as a single-cycle strobe. If held high for k cycles, k pushes occur.

Test Plan:
- Reset, push 0x41, 0x42, 0x43 on separate strobes with dout_ready=0 -> count=3, dout=0x41, dout_valid=1. Then hold dout_ready=1 -> dout presents 0x42, then 0x43, then 0 with dout_valid=0, count=0.
- DEPTH=16: push 0x00..0x0F -> full=1, count=16. Push 0xAA -> overrun=1, dout still 0x00. Drain all 16 -> values 0x00..0x0F in order, 0xAA never appears. Pulse clr_overrun -> overrun=0.
- Full queue, din_valid=1 with 0x55 while dout_ready=1 -> count stays 16, overrun=0. 0x55 emerges last after draining.
- Parity tag: push 0x12 with din_perr=1 under DROP_PERR=0 -> dout=0x12, dout_perr=1. Repeat under DROP_PERR=1 -> nothing stored, count=0, overrun=0.
- rts_n (AF_LEVEL=12): push 11 bytes -> rts_n=0. Push 12th -> rts_n=1 on that edge. Pop one -> rts_n=0.
- Wrap-around and reset: run 40 bytes through with random dout_ready -> output order and data identical to input. Assert rst low mid-stream with count=5 -> immediately count=0, dout_valid=0, overrun=0, rts_n=0.
